// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache.
// One 32-bit word per line. Replacement is true LRU.
// Misses write back a dirty victim before the fill, over a req/ack bus.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   ren/wen/byte_selector      load/store request and store byte enables
//   address/datawr             byte address and store data
//   dataout/done/miss          load data, completion pulse, miss flag
//   mem_req/mem_we/mem_addr    memory request (write-back or fill)
//   mem_wdata/mem_rdata        write-back data / fill data
//   mem_ack                    memory completion
// Build option: define CACHE_STATS_EN to add the hit_count and
// miss_count outputs.
module set_assoc_wb_cache #(
   parameter int SETS   = 8,
   parameter int WAYS   = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ren,
   input  logic              wen,
   input  logic [3:0]        byte_selector,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       datawr,
   output logic [31:0]       dataout,
   output logic              done,
   output logic              miss,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WAY_W = AGE_W;
   localparam int TAG_W = ADDR_W - 2 - IDX_W;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_FILL,
      S_RESP
   } state_t;

   state_t state_q, state_d;

   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   logic [AGE_W-1:0] age_q   [SETS][WAYS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [31:0]      data_q  [SETS][WAYS];

   // request captured at miss detection
   logic [ADDR_W-3:0] rq_waddr;
   logic              rq_we;
   logic [3:0]        rq_be;
   logic [31:0]       rq_wdata;
   logic [WAY_W-1:0]  vic_q;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tg;
   logic [IDX_W-1:0] rq_idx;
   logic [TAG_W-1:0] rq_tag;
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             inv_any;
   logic [WAY_W-1:0] vic_way;
   logic             req_one;

   logic              done_d;
   logic              miss_d;
   logic              mem_req_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [31:0]       mem_wdata_d;
   logic [31:0]       dataout_d;

   logic             latch_en;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [WAY_W-1:0] wr_way;
   logic [TAG_W-1:0] wr_tag;
   logic [31:0]      wr_data;
   logic             wr_dirty;
   logic [AGE_W-1:0] wr_old_age;

   logic unused_addr;
   assign unused_addr = ^address[1:0];

   function automatic logic [31:0] merge(
      input logic [31:0] old_d,
      input logic [31:0] new_d,
      input logic [3:0]  be
   );
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
      end
      return r;
   endfunction

   assign idx     = address[IDX_W+1:2];
   assign tg      = address[ADDR_W-1:IDX_W+2];
   assign rq_idx  = rq_waddr[IDX_W-1:0];
   assign rq_tag  = rq_waddr[ADDR_W-3:IDX_W];
   assign req_one = ren ^ wen;

   // lookup and victim selection on the live request
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      vic_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tg) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // descending scan leaves the lowest invalid way
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) begin
            inv_any = 1'b1;
            vic_way = WAY_W'(w);
         end
      end
      if (!inv_any) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx][w] == AGE_MAX) vic_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      miss_d      = miss;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      dataout_d   = dataout;
      latch_en    = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = idx;
      wr_way      = hit_way;
      wr_tag      = tg;
      wr_data     = data_q[idx][hit_way];
      wr_dirty    = dirty_q[idx][hit_way];
      unique case (state_q)
         S_IDLE: begin
            // done high means the finished request is still presented
            if (!done && req_one) begin
               if (hit) begin
                  done_d = 1'b1;
                  wr_en  = 1'b1;
                  if (wen) begin
                     wr_data  = merge(data_q[idx][hit_way], datawr,
                                      byte_selector);
                     wr_dirty = 1'b1;
                  end else begin
                     dataout_d = data_q[idx][hit_way];
                  end
               end else begin
                  latch_en  = 1'b1;
                  miss_d    = 1'b1;
                  mem_req_d = 1'b1;
                  if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
                     state_d     = S_WB;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = {tag_q[idx][vic_way], idx, 2'b00};
                     mem_wdata_d = data_q[idx][vic_way];
                  end else begin
                     state_d    = S_FILL;
                     mem_we_d   = 1'b0;
                     mem_addr_d = {address[ADDR_W-1:2], 2'b00};
                  end
               end
            end
         end
         S_WB: begin
            if (mem_ack) begin
               state_d    = S_FILL;
               mem_we_d   = 1'b0;
               mem_addr_d = {rq_waddr, 2'b00};
            end
         end
         S_FILL: begin
            wr_idx   = rq_idx;
            wr_way   = vic_q;
            wr_tag   = rq_tag;
            wr_data  = mem_rdata;
            wr_dirty = 1'b0;
            if (mem_ack) begin
               state_d   = S_RESP;
               wr_en     = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (rq_we) begin
                  wr_data  = merge(mem_rdata, rq_wdata, rq_be);
                  wr_dirty = 1'b1;
               end else begin
                  dataout_d = mem_rdata;
               end
            end
         end
         S_RESP: begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            miss_d    = 1'b0;
            mem_req_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_old_age = age_q[wr_idx][wr_way];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         dataout   <= '0;
         done      <= 1'b0;
         miss      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_q   <= state_d;
         dataout   <= dataout_d;
         done      <= done_d;
         miss      <= miss_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

   // state bits with reset; ages restart as identity permutation
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= AGE_W'(w);
            end
         end
      end else if (wr_en) begin
         valid_q[wr_idx][wr_way] <= 1'b1;
         dirty_q[wr_idx][wr_way] <= wr_dirty;
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == wr_way) begin
               age_q[wr_idx][w] <= '0;
            end else if (age_q[wr_idx][w] < wr_old_age) begin
               age_q[wr_idx][w] <= age_q[wr_idx][w] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx][wr_way]  <= wr_tag;
         data_q[wr_idx][wr_way] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (latch_en) begin
         rq_waddr <= address[ADDR_W-1:2];
         rq_we    <= wen;
         rq_be    <= byte_selector;
         rq_wdata <= datawr;
         vic_q    <= vic_way;
      end
   end

`ifdef CACHE_STATS_EN
   logic hit_inc;
   logic miss_inc;

   assign hit_inc  = (state_q == S_IDLE) && !done && req_one && hit;
   assign miss_inc = (state_q == S_RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc)  hit_count  <= hit_count + 32'd1;
         if (miss_inc) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Directed bench for set_assoc_wb_cache with a memory responder.
// Load results and memory transactions are checked from scoreboards.
module tb_set_assoc_wb_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic        ren, wen;
   logic [3:0]  byte_selector;
   logic [31:0] address, datawr;
   logic [31:0] dataout;
   logic        done, miss;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   set_assoc_wb_cache #(.SETS(8), .WAYS(2), .ADDR_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .ren           (ren),
      .wen           (wen),
      .byte_selector (byte_selector),
      .address       (address),
      .datawr        (datawr),
      .dataout       (dataout),
      .done          (done),
      .miss          (miss),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack)
`ifdef CACHE_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      bit          ld;
      bit          miss;
      int          lat;
   } exp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mtx_t;

   exp_t sb[$];
   mtx_t mq[$];
   logic [31:0] mem [logic [31:0]];
   int total = 0;
   int bad = 0;
   int mem_lat = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic exp_mem(input bit we, input logic [31:0] a,
                          input logic [31:0] d);
      mtx_t m;
      m.we = we;
      m.addr = a;
      m.wdata = d;
      mq.push_back(m);
   endtask

   // memory: checks each new request, acks after mem_lat cycles
   initial begin
      mtx_t m;
      bit ok;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req === 1'b1) begin
            if (mq.size() == 0) begin
               chk("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
               m = mq.pop_front();
               chk("mem_we", 32'(mem_we), 32'(m.we));
               chk("mem_addr", mem_addr, m.addr);
               if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            end
            ok = 1'b1;
            for (int k = 0; k < mem_lat; k++) begin
               @(negedge clk);
               if (mem_req !== 1'b1) begin
                  ok = 1'b0;
                  break;
               end
            end
            if (ok) begin
               mem_ack = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else mem_rdata = rd(mem_addr);
            end
         end
      end
   end

   task automatic do_req(input bit ld, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input bit xmiss, input int xlat,
                         input logic [31:0] xd);
      exp_t e;
      int cyc;
      bit sm, sr, got;
      @(negedge clk);
      ren = ld;
      wen = !ld;
      address = a;
      datawr = d;
      byte_selector = be;
      e.data = xd;
      e.ld = ld;
      e.miss = xmiss;
      e.lat = xlat;
      sb.push_back(e);
      cyc = 0;
      sm = 0;
      sr = 0;
      got = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (miss) sm = 1;
         if (mem_req) sr = 1;
         if (done) got = 1;
      end
      ren = 1'b0;
      wen = 1'b0;
      e = sb.pop_front();
      if (!got) begin
         chk("done_timeout", 32'(cyc), 32'(e.lat));
      end else begin
         chk("latency", 32'(cyc), 32'(e.lat));
         chk("miss_seen", 32'(sm), 32'(e.miss));
         chk("memreq_seen", 32'(sr), 32'(e.miss));
         if (e.ld) chk("dataout", dataout, e.data);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ren = 1'b0;
      wen = 1'b0;
      byte_selector = '0;
      address = '0;
      datawr = '0;
      mem[32'h10] = 32'hDEAD_BEEF;
      mem[32'h30] = 32'h3030_3030;
      mem[32'h50] = 32'h5050_5050;
      repeat (3) @(negedge clk);
      chk("rst_dataout", dataout, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_miss", 32'(miss), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
`ifdef CACHE_STATS_EN
      chk("rst_hits", hit_count, 0);
      chk("rst_misses", miss_count, 0);
`endif
      reset = 1'b0;

      // cold miss then hit
      mem_lat = 0;
      exp_mem(0, 32'h10, 0);
      do_req(1, 32'h10, 0, 0, 1, 3, 32'hDEAD_BEEF);
      do_req(1, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF);

      // partial store hit
      do_req(0, 32'h10, 32'h1122_3344, 4'b0011, 0, 1, 0);
`ifdef CACHE_STATS_EN
      chk("hit_count", hit_count, 2);
      chk("miss_count", miss_count, 1);
`endif
      do_req(1, 32'h10, 0, 0, 0, 1, 32'hDEAD_3344);

      // LRU victim choice in set 4
      mem_lat = 2;
      exp_mem(0, 32'h30, 0);
      do_req(1, 32'h30, 0, 0, 1, 5, 32'h3030_3030);
      do_req(1, 32'h10, 0, 0, 0, 1, 32'hDEAD_3344);
      exp_mem(0, 32'h50, 0);
      do_req(1, 32'h50, 0, 0, 1, 5, 32'h5050_5050);
      do_req(1, 32'h10, 0, 0, 0, 1, 32'hDEAD_3344);
      exp_mem(0, 32'h30, 0);
      do_req(1, 32'h30, 0, 0, 1, 5, 32'h3030_3030);

      // reset while waiting for a fill
      mem_lat = 20;
      exp_mem(0, 32'h74, 0);
      @(negedge clk);
      ren = 1'b1;
      address = 32'h74;
      repeat (3) @(negedge clk);
      chk("mid_miss", 32'(miss), 1);
      chk("mid_mem_req", 32'(mem_req), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_mem_req", 32'(mem_req), 0);
      chk("rst_mid_miss", 32'(miss), 0);
      chk("rst_mid_done", 32'(done), 0);
      ren = 1'b0;
      reset = 1'b0;

      // dirty data was lost: memory still holds the original word
      mem_lat = 1;
      exp_mem(0, 32'h10, 0);
      do_req(1, 32'h10, 0, 0, 1, 4, 32'hDEAD_BEEF);

      // dirty eviction: write-back precedes fill
      do_req(0, 32'h10, 32'hA1B2_C3D4, 4'b1100, 0, 1, 0);
      exp_mem(0, 32'h30, 0);
      do_req(1, 32'h30, 0, 0, 1, 4, 32'h3030_3030);
      exp_mem(1, 32'h10, 32'hA1B2_BEEF);
      exp_mem(0, 32'h50, 0);
      do_req(1, 32'h50, 0, 0, 1, 6, 32'h5050_5050);
      exp_mem(0, 32'h10, 0);
      do_req(1, 32'h10, 0, 0, 1, 4, 32'hA1B2_BEEF);

      // zero byte-enable store dirties the line without changing it
      do_req(0, 32'h50, 32'hFFFF_FFFF, 4'b0000, 0, 1, 0);
      exp_mem(0, 32'h30, 0);
      do_req(1, 32'h30, 0, 0, 1, 4, 32'h3030_3030);
      exp_mem(1, 32'h50, 32'h5050_5050);
      exp_mem(0, 32'h70, 0);
      do_req(1, 32'h70, 0, 0, 1, 6, 32'hC0DE_0070);
      exp_mem(0, 32'h50, 0);
      do_req(1, 32'h50, 0, 0, 1, 4, 32'h5050_5050);

      // conflicting request is ignored
      @(negedge clk);
      ren = 1'b1;
      wen = 1'b1;
      address = 32'h10;
      repeat (5) begin
         @(negedge clk);
         chk("both_done", 32'(done), 0);
         chk("both_mem_req", 32'(mem_req), 0);
      end
      ren = 1'b0;
      wen = 1'b0;
      repeat (2) @(negedge clk);

      chk("mem_left", 32'(mq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
